// File: rtl/deser_8way_pkg.sv
// Shared types and constants for the 8-way serial-to-parallel deserializer.
// DESER8_PARITY_EN adds a ninth even-parity bit per byte.
package deser_8way_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

`ifdef DESER8_PARITY_EN
    localparam logic [CNT_W-1:0] LAST = 4'd8;
`else
    localparam logic [CNT_W-1:0] LAST = 4'd7;
`endif

    typedef enum logic {
        BUF_EMPTY,
        BUF_FULL
    } buf_state_e;

endpackage

// File: rtl/deser_8way_parity_xor9.sv
// Nine-input XOR reduction used for the byte parity check.
// Only instantiated when DESER8_PARITY_EN is defined.
module parity_xor9 (
    input  logic [8:0] d_i,
    output logic       p_o
);

    assign p_o = ^d_i;

endmodule

// File: rtl/deser_8way.sv
// Serial-to-parallel deserializer: one bit per handshake in, bytes out.
// Build option DESER8_PARITY_EN appends a checked even-parity bit per byte.
module deser_8way
    import deser_8way_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sync_err,
    output logic              par_err
);

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sync_q, sync_d;
    buf_state_e        state_q, state_d;

    logic              accept;
    logic              consume;
    logic              done;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] sof_word;
    logic [DATA_W-1:0] byte_w;

    assign out_valid = (state_q == BUF_FULL);
    assign in_ready  = !(out_valid && !out_ready && cnt_q == LAST);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign done      = accept && !in_sof && cnt_q == LAST;

    assign shifted  = MSB_FIRST ? {sr_q[DATA_W-2:0], in_bit}
                                : {in_bit, sr_q[DATA_W-1:1]};
    assign sof_word = MSB_FIRST ? {{(DATA_W-1){1'b0}}, in_bit}
                                : {in_bit, {(DATA_W-1){1'b0}}};

`ifdef DESER8_PARITY_EN
    logic par_q, par_d;
    logic perr;

    // Completing bit is the parity bit; data is already whole in sr_q.
    assign byte_w = sr_q;

    parity_xor9 u_par (
        .d_i({sr_q, in_bit}),
        .p_o(perr)
    );

    always_comb begin
        par_d = par_q;
        if (done) begin
            par_d = perr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_err = par_q;
`else
    assign byte_w  = shifted;
    assign par_err = 1'b0;
`endif

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sync_d  = 1'b0;
        state_d = state_q;

        if (accept) begin
            if (in_sof) begin
                // Resynchronise: partial byte is dropped.
                sr_d   = sof_word;
                cnt_d  = 4'd1;
                sync_d = (cnt_q != '0);
            end else if (cnt_q == LAST) begin
                sr_d   = '0;
                cnt_d  = '0;
                data_d = byte_w;
            end else begin
                sr_d  = shifted;
                cnt_d = cnt_q + 4'd1;
            end
        end

        unique case (state_q)
            BUF_EMPTY: if (done) state_d = BUF_FULL;
            BUF_FULL:  if (consume && !done) state_d = BUF_EMPTY;
            default:   state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            sync_q  <= 1'b0;
            state_q <= BUF_EMPTY;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sync_q  <= sync_d;
            state_q <= state_d;
        end
    end

    assign out_data = data_q;
    assign sync_err = sync_q;

endmodule
